float_divider: RTL and testbench
================================

FLOAT_DIVIDER -- requirements
Module: float_divider

Interface
REQ-001 clk  input  1  single system clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  request pulse; sampled only while busy=0.
REQ-004 float_a  input  24  dividend: [23] sign, [22:16] exponent (bias 63), [15:0] fraction; hidden leading 1.
REQ-005 float_b  input  24  divisor, same format as float_a.
REQ-006 busy  output  1  high from the cycle after start is accepted until done.
REQ-007 done  output  1  one-cycle pulse; result outputs are valid from this cycle.
REQ-008 float_out  output  24  quotient, same format; registered, held until the next done.
REQ-009 float_out_overflow  output  1  quotient exponent above 127; registered with float_out.
REQ-010 float_out_underflow  output  1  quotient exponent below 1; registered with float_out.
REQ-011 float_out_div_zero  output  1  divisor is zero; registered with float_out.

Function
REQ-012 Any operand with exponent field 0 SHALL be treated as zero; fraction is ignored.
REQ-013 On accept (start=1, busy=0), the block SHALL capture float_a and float_b; later input changes SHALL have no effect.
REQ-014 FSM states SHALL be IDLE, DIVIDE, NORMALISE and DONE.
REQ-015 Transitions: IDLE->DIVIDE on accept; DIVIDE->NORMALISE after the last quotient bit; NORMALISE->DONE; DONE->IDLE unconditionally.
REQ-016 DIVIDE SHALL run restoring division of {1,frac_a} by {1,frac_b} (17-bit each), producing 1 quotient bit per cycle, 18 bits total (19 with FDIV_ROUND_EN).
REQ-017 Latency SHALL be fixed for all operands, including zero, div-zero and overflow cases: done asserts exactly 21 cycles after the accept edge (22 with FDIV_ROUND_EN).
REQ-018 start asserted while busy=1 SHALL be ignored; start asserted in the DONE cycle SHALL be ignored.
REQ-019 Sign SHALL be sign_a XOR sign_b in all cases.
REQ-020 Exponent SHALL be computed in 9-bit signed arithmetic: exp_a - exp_b + 63.
REQ-021 Normalisation: if the quotient integer bit is 0, the block SHALL shift left 1 and decrement the exponent; the fraction is the 16 bits following the leading 1.
REQ-022 Overflow: if final exponent > 127, the result SHALL be {sign,7'h7F,16'hFFFF} with float_out_overflow=1.
REQ-023 Underflow: if final exponent < 1, the result SHALL be {sign,23'h0} with float_out_underflow=1.
REQ-024 Div-zero: if b is zero, the result SHALL be {sign,7'h7F,16'hFFFF} with float_out_div_zero=1 and the other flags 0; this case takes precedence over all others.
REQ-025 If a is zero and b is non-zero, the result SHALL be {sign,23'h0} with all flags 0.
REQ-026 Flags SHALL update only at done and SHALL hold with float_out.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE and busy=0, done=0, float_out=0, and all flags=0.
REQ-028 rst asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-029 With FDIV_ROUND_EN defined, the block SHALL compute one guard bit and round half-up; a fraction carry-out SHALL increment the exponent, and overflow is checked after rounding.
REQ-030 Without FDIV_ROUND_EN, the block SHALL truncate with no guard-bit hardware.

Verification
REQ-031 0x418000 / 0x408000 (6/3) -> float_out=0x400000, all flags 0, done exactly 21 cycles after accept.
REQ-032 0x3F0000 / 0x3F4000 (1/1.25) -> 0x3E9999 without FDIV_ROUND_EN; 0x3E999A with it.
REQ-033 0xC18000 / 0x408000 -> 0xC00000; 0x3F0000 / 0x400000 -> 0x3E0000.
REQ-034 0x7F0000 / 0x010000 -> 0x7FFFFF with overflow=1; 0x010000 / 0x7F0000 -> 0x000000 with underflow=1.
REQ-035 0x3F0000 / 0x000000 -> 0x7FFFFF with div_zero=1; 0x000000 / 0x3F0000 -> 0x000000, all flags 0.
REQ-036 Second start at cycle 5 of an operation is ignored, with exactly one done pulse; rst at cycle 10 gives no done and all outputs 0, and a subsequent start completes normally.

Source files
------------

// File: rtl/float_divider.sv
// Sequential 24-bit float divider (1 sign, 7-bit exponent bias 63, 16-bit fraction) using restoring division.
// Define FDIV_ROUND_EN to add a guard bit with round-half-up; the default build truncates.
module float_divider (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [23:0] float_a,
   input  logic [23:0] float_b,
   output logic        busy,
   output logic        done,
   output logic [23:0] float_out,
   output logic        float_out_overflow,
   output logic        float_out_underflow,
   output logic        float_out_div_zero
);

`ifdef FDIV_ROUND_EN
   localparam int QBITS = 19;
`else
   localparam int QBITS = 18;
`endif
   // DIVIDE runs one setup step, QBITS quotient steps and one alignment step.
   localparam logic [4:0] CNT_BITS = 5'(QBITS);
   localparam logic [4:0] CNT_LAST = 5'(QBITS + 1);

   typedef enum logic [1:0] {IDLE, DIVIDE, NORMALISE, DONE} state_t;

   state_t            state, state_nx;
   logic [4:0]        cnt;
   logic [23:0]       a_r, b_r;
   logic [17:0]       rem;
   logic [16:0]       divisor;
   logic [QBITS-1:0]  quo;
   logic signed [8:0] exp_r;

   logic              a_zero, b_zero, sign;
   logic [15:0]       frac;
   logic signed [8:0] exp_f;
   logic [23:0]       res;
   logic              res_ov, res_un, res_dz;

   assign a_zero = (a_r[22:16] == 7'd0);
   assign b_zero = (b_r[22:16] == 7'd0);
   assign sign   = a_r[23] ^ b_r[23];
   assign busy   = (state != IDLE);
   assign done   = (state == DONE);

   // NOTE: datapath registers carry no reset; nothing reads them before an accepted start reloads them.
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         a_r <= float_a;
         b_r <= float_b;
      end
      if (state == DIVIDE) begin
         if (cnt == 5'd0) begin
            rem     <= {2'b01, a_r[15:0]};
            divisor <= {1'b1, b_r[15:0]};
            quo     <= '0;
            exp_r   <= $signed({2'b00, a_r[22:16]}) - $signed({2'b00, b_r[22:16]}) + 9'sd63;
         end else if (cnt <= CNT_BITS) begin
            if (rem >= {1'b0, divisor}) begin
               rem <= (rem - {1'b0, divisor}) << 1;
               quo <= {quo[QBITS-2:0], 1'b1};
            end else begin
               rem <= rem << 1;
               quo <= {quo[QBITS-2:0], 1'b0};
            end
         end else if (!quo[QBITS-1]) begin
            // Quotient below 1.0: bring the leading one to the top.
            quo   <= quo << 1;
            exp_r <= exp_r - 9'sd1;
         end
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      frac  = quo[QBITS-2 -: 16];
      exp_f = exp_r;
`ifdef FDIV_ROUND_EN
      begin
         logic carry;
         {carry, frac} = {1'b0, quo[QBITS-2 -: 16]} + 17'(quo[QBITS-18]);
         if (carry) exp_f = exp_r + 9'sd1;
      end
`endif
      res    = {sign, 23'h0};
      res_ov = 1'b0;
      res_un = 1'b0;
      res_dz = 1'b0;
      if (b_zero) begin
         res    = {sign, 7'h7F, 16'hFFFF};
         res_dz = 1'b1;
      end else if (a_zero) begin
         res = {sign, 23'h0};
      end else if (exp_f > 9'sd127) begin
         res    = {sign, 7'h7F, 16'hFFFF};
         res_ov = 1'b1;
      end else if (exp_f < 9'sd1) begin
         res    = {sign, 23'h0};
         res_un = 1'b1;
      end else begin
         res = {sign, exp_f[6:0], frac};
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:      if (start) state_nx = DIVIDE;
         DIVIDE:    if (cnt == CNT_LAST) state_nx = NORMALISE;
         NORMALISE: state_nx = DONE;
         DONE:      state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state               <= IDLE;
         cnt                 <= 5'd0;
         float_out           <= 24'h0;
         float_out_overflow  <= 1'b0;
         float_out_underflow <= 1'b0;
         float_out_div_zero  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= (state == DIVIDE) ? cnt + 5'd1 : 5'd0;
         if (state == NORMALISE) begin
            float_out           <= res;
            float_out_overflow  <= res_ov;
            float_out_underflow <= res_un;
            float_out_div_zero  <= res_dz;
         end
      end
   end

endmodule

// File: tb/tb_float_divider.sv
// Self-checking bench for float_divider: arithmetic reference model, per-done compare process,
// directed vectors with literal expectations, abort-by-reset and ignored-start scenarios.
module tb_float_divider;

`ifdef FDIV_ROUND_EN
   localparam int LAT = 22;
   localparam logic [23:0] Q_1_125 = 24'h3E999A;
`else
   localparam int LAT = 21;
   localparam logic [23:0] Q_1_125 = 24'h3E9999;
`endif

   logic        clk = 1'b0;
   logic        rst, start;
   logic [23:0] float_a, float_b;
   logic        busy, done;
   logic [23:0] float_out;
   logic        float_out_overflow, float_out_underflow, float_out_div_zero;

   float_divider dut (
      .clk(clk), .rst(rst), .start(start), .float_a(float_a), .float_b(float_b),
      .busy(busy), .done(done), .float_out(float_out),
      .float_out_overflow(float_out_overflow), .float_out_underflow(float_out_underflow),
      .float_out_div_zero(float_out_div_zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [23:0] out;
      logic        ov, un, dz;
      int          acc;
   } res_t;

   res_t q[$];
   res_t mon_e;
   int   n_cmp = 0, n_bad = 0, n_done = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Quotient from plain integer division of the significands, then the format's rules.
   function automatic res_t model(input logic [23:0] a, input logic [23:0] b);
      res_t   r;
      longint ma, mb, sig;
      int     e;
      r.acc = 0; r.ov = 1'b0; r.un = 1'b0; r.dz = 1'b0;
      r.out = {a[23] ^ b[23], 23'h0};
      if (b[22:16] == 7'd0) begin
         r.out[22:0] = 23'h7FFFFF;
         r.dz = 1'b1;
      end else if (a[22:16] != 7'd0) begin
         ma = longint'({1'b1, a[15:0]});
         mb = longint'({1'b1, b[15:0]});
         e  = int'(a[22:16]) - int'(b[22:16]) + 63;
         if (ma < mb) begin
            ma = ma * 2;
            e  = e - 1;
         end
`ifdef FDIV_ROUND_EN
         sig = (ma << 17) / mb;
         sig = (sig + 1) >> 1;
         if (sig >= 64'd131072) begin
            sig = sig >> 1;
            e   = e + 1;
         end
`else
         sig = (ma << 16) / mb;
`endif
         if (e > 127) begin
            r.out[22:0] = 23'h7FFFFF;
            r.ov = 1'b1;
         end else if (e < 1) begin
            r.un = 1'b1;
         end else begin
            r.out[22:0] = {7'(e), sig[15:0]};
         end
      end
      return r;
   endfunction

   // Compare process: every done pulse must match the oldest accepted operation.
   always @(negedge clk) begin
      if (done) begin
         n_done++;
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 required no pending operation (t=%0t)", $time);
         end else begin
            mon_e = q.pop_front();
            check("float_out", float_out, mon_e.out);
            check("overflow", float_out_overflow, mon_e.ov);
            check("underflow", float_out_underflow, mon_e.un);
            check("div_zero", float_out_div_zero, mon_e.dz);
            check("latency", cyc - mon_e.acc, LAT);
         end
      end
   end

   task automatic op(input logic [23:0] a, input logic [23:0] b, input int poke,
                     input bit has_lit, input logic [23:0] lit, input string name);
      res_t e;
      int   t;
      @(negedge clk);
      float_a = a; float_b = b; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      float_a = 24'($urandom); float_b = 24'($urandom);
      e = model(a, b);
      e.acc = cyc;
      q.push_back(e);
      check({name, "_busy"}, busy, 1);
      t = 0;
      while (!done && t < LAT + 8) begin
         @(negedge clk);
         t++;
         if (t == poke) begin
            start = 1'b1; float_a = 24'h7F0000; float_b = 24'h010000;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: got no done required done within %0d cycles", name, LAT + 8);
      end else begin
         if (has_lit) check({name, "_lit"}, float_out, lit);
         start = 1'b1; float_a = 24'h418000; float_b = 24'h408000;
         @(posedge clk);
         #1;
         start = 1'b0;
         @(negedge clk);
         check({name, "_start_in_done_ignored"}, busy, 0);
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1, "watchdog");
   end

   initial begin
      res_t r;
      int   d0;
      rst = 1'b1; start = 1'b0; float_a = '0; float_b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_out", float_out, 0);
      check("rst_flags", {float_out_overflow, float_out_underflow, float_out_div_zero}, 0);
      @(negedge clk);
      rst = 1'b0;

      // Pin the model against hand-computed values.
      r = model(24'h418000, 24'h408000); check("pin_6div3", r.out, 24'h400000);
      r = model(24'h3F0000, 24'h3F4000); check("pin_1div1p25", r.out, Q_1_125);
      r = model(24'h7F0000, 24'h010000); check("pin_ovf", {r.ov, r.un, r.dz, r.out}, {3'b100, 24'h7FFFFF});
      r = model(24'h010000, 24'h7F0000); check("pin_unf", {r.ov, r.un, r.dz, r.out}, {3'b010, 24'h000000});
      r = model(24'h3F0000, 24'h000000); check("pin_dz", {r.ov, r.un, r.dz, r.out}, {3'b001, 24'h7FFFFF});

      op(24'h418000, 24'h408000, -1, 1, 24'h400000, "six_by_three");
      op(24'h3F0000, 24'h3F4000, -1, 1, Q_1_125,    "one_by_1p25");
      op(24'hC18000, 24'h408000, -1, 1, 24'hC00000, "neg_six_by_three");
      op(24'h3F0000, 24'h400000, -1, 1, 24'h3E0000, "one_by_two");
      op(24'h7F0000, 24'h010000, -1, 1, 24'h7FFFFF, "overflow");
      op(24'h010000, 24'h7F0000, -1, 1, 24'h000000, "underflow");
      op(24'h3F0000, 24'h000000, -1, 1, 24'h7FFFFF, "div_zero");
      op(24'h000000, 24'h3F0000, -1, 1, 24'h000000, "zero_dividend");
      op(24'h80ABCD, 24'h3F0000, -1, 1, 24'h800000, "zero_exp_frac_ignored");
      op(24'h3F0000, 24'h80FFFF, -1, 1, 24'hFFFFFF, "div_zero_neg");
      op(24'h000000, 24'h000000, -1, 1, 24'h7FFFFF, "zero_by_zero");
      op(24'h7F0000, 24'h3F0000, -1, 1, 24'h7F0000, "exp_max_edge");
      op(24'h010000, 24'h3F0000, -1, 1, 24'h010000, "exp_min_edge");
      op(24'h010000, 24'h3F8000, -1, 1, 24'h000000, "underflow_by_normalise");
      op(24'h3FFFFF, 24'h3F0000, -1, 1, 24'h3FFFFF, "max_fraction");
      op(24'h3F0000, 24'h400000,  5, 1, 24'h3E0000, "start_while_busy");

      for (int i = 0; i < 12; i++) begin
         op({1'($urandom), 7'($urandom_range(20, 100)), 16'($urandom)},
            {1'($urandom), 7'($urandom_range(20, 100)), 16'($urandom)}, -1, 0, 24'h0, "random");
      end

      // Abort by reset at cycle 10 of an operation.
      @(negedge clk);
      float_a = 24'h418000; float_b = 24'h408000; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      r = model(24'h418000, 24'h408000);
      r.acc = cyc;
      q.push_back(r);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_out", float_out, 0);
      check("abort_flags", {float_out_overflow, float_out_underflow, float_out_div_zero}, 0);
      q.delete();
      d0 = n_done;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (LAT + 5) @(negedge clk);
      check("abort_no_done", n_done - d0, 0);
      op(24'hC18000, 24'h408000, -1, 1, 24'hC00000, "after_abort");

      check("pending_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
